estimador_pipe_mux: RTL and testbench

ESTIMADOR_PIPE_MUX -- requirements
Module: estimador_pipe_mux

---
 rtl/estimador_mux_pkg.sv | 41 ++++
 rtl/estimador_mux_level.sv | 56 +++++
 rtl/estimador_pipe_mux.sv | 120 ++++++++++++
 tb/tb_estimador_pipe_mux.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/estimador_mux_pkg.sv
// Shared helpers for the estimador pipelined mux: tree sizing and pipeline register placement.
package estimador_mux_pkg;

  localparam int MAX_POS = 8;

  function automatic int clog2(input int n);
    int r = 0;
    int v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int levels(input int n);
    int v = n;
    int d = 0;
    while (v > 1) begin
      v = (v + 1) / 2;
      d = d + 1;
    end
    return d;
  endfunction

  function automatic int nodes_at(input int n, input int lvl);
    int v = n;
    for (int i = 0; i < lvl; i++) v = (v + 1) / 2;
    return v;
  endfunction

  // Bit 0 is an input register, bit j+1 a register after level j; filled from the output backwards.
  function automatic logic [MAX_POS-1:0] stage_flags(input int lvls, input int num_stage);
    logic [MAX_POS-1:0] f = '0;
    for (int p = 0; p <= lvls && p < MAX_POS; p++) begin
      if (p > lvls - num_stage) f[p] = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/estimador_mux_level.sv
// One level of the selection tree: pairwise 2:1 muxes steered by src_sel[0], optionally registered.
module estimador_mux_level #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 3,
  parameter int SEL_W  = 2,
  parameter bit REG    = 1'b1
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  input  logic                              ce,
  input  logic                              src_vld,
  input  logic [N_IN*DATA_W-1:0]            src_data,
  input  logic [SEL_W-1:0]                  src_sel,
  output logic                              res_vld,
  output logic [((N_IN+1)/2)*DATA_W-1:0]    res_data,
  output logic [SEL_W-1:0]                  res_sel
);

  localparam int N_OUT = (N_IN + 1) / 2;

  logic [N_OUT*DATA_W-1:0] mux_data;

  // The last node of an odd-sized level has no partner and passes straight through.
  for (genvar k = 0; k < N_OUT; k++) begin : g_node
    if (2 * k + 1 < N_IN) begin : g_pair
      assign mux_data[k*DATA_W +: DATA_W] = src_sel[0] ? src_data[(2*k+1)*DATA_W +: DATA_W]
                                                       : src_data[(2*k)*DATA_W +: DATA_W];
    end else begin : g_pass
      assign mux_data[k*DATA_W +: DATA_W] = src_data[(2*k)*DATA_W +: DATA_W];
    end
  end

  if (REG) begin : g_reg
    // Bubbles advance the valid bit only, so data and sel stay quiet between samples.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        res_vld  <= 1'b0;
        res_data <= '0;
        res_sel  <= '0;
      end else if (ce) begin
        res_vld <= src_vld;
        if (src_vld) begin
          res_data <= mux_data;
          res_sel  <= src_sel >> 1;
        end
      end
    end
  end else begin : g_wire
    logic ctl_unused;
    assign ctl_unused = ap_clk ^ ap_rst ^ ce;
    assign res_vld    = src_vld;
    assign res_data   = mux_data;
    assign res_sel    = src_sel >> 1;
  end

endmodule

// File: rtl/estimador_pipe_mux.sv
// Pipelined NUM_IN:1 mux built as a binary tree of estimador_mux_level stages.
// Define ESTIMADOR_MUX_SEL_CHECK_EN to add the sticky sel_err flag and zero out-of-range samples.
module estimador_pipe_mux
  import estimador_mux_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_IN    = 3,
  parameter int NUM_STAGE = 1,
  parameter int SEL_W     = clog2(NUM_IN)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ce,
  input  logic                     din_vld,
  input  logic [NUM_IN*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_vld
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
  ,
  output logic                     sel_err
`endif
);

  localparam logic [MAX_POS-1:0] REG_AT = stage_flags(SEL_W, NUM_STAGE);

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $fatal(1, "estimador_pipe_mux: NUM_IN must be within 2..16");
  end
  if (NUM_STAGE < 1 || NUM_STAGE > SEL_W + 1) begin : g_bad_num_stage
    $fatal(1, "estimador_pipe_mux: NUM_STAGE must be within 1..SEL_W+1");
  end
  if (SEL_W != clog2(NUM_IN) || SEL_W != levels(NUM_IN)) begin : g_bad_sel_w
    $fatal(1, "estimador_pipe_mux: SEL_W is derived from NUM_IN and must not be overridden");
  end

  logic [NUM_IN*DATA_W-1:0] tree_din;
  logic [NUM_IN*DATA_W-1:0] s0_data;
  logic                     s0_vld;
  logic [SEL_W-1:0]         s0_sel;

`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
  logic sel_bad;
  assign sel_bad  = int'(sel) >= NUM_IN;
  // Masking the whole input makes the tree's pass-through result zero for a bad sel.
  assign tree_din = sel_bad ? '0 : din;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) sel_err <= 1'b0;
    else if (ce && din_vld && sel_bad) sel_err <= 1'b1;
  end
`else
  assign tree_din = din;
`endif

  if (REG_AT[0]) begin : g_in_reg
    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        s0_vld  <= 1'b0;
        s0_data <= '0;
        s0_sel  <= '0;
      end else if (ce) begin
        s0_vld <= din_vld;
        if (din_vld) begin
          s0_data <= tree_din;
          s0_sel  <= sel;
        end
      end
    end
  end else begin : g_in_wire
    assign s0_vld  = din_vld;
    assign s0_data = tree_din;
    assign s0_sel  = sel;
  end

  for (genvar j = 0; j < SEL_W; j++) begin : g_lvl
    localparam int N_IN_J  = nodes_at(NUM_IN, j);
    localparam int N_OUT_J = nodes_at(NUM_IN, j + 1);

    logic [N_IN_J*DATA_W-1:0]  src_data;
    logic                      src_vld;
    logic [SEL_W-1:0]          src_sel;
    logic [N_OUT_J*DATA_W-1:0] res_data;
    logic                      res_vld;
    logic [SEL_W-1:0]          res_sel;

    if (j == 0) begin : g_first
      assign src_data = s0_data;
      assign src_vld  = s0_vld;
      assign src_sel  = s0_sel;
    end else begin : g_next
      assign src_data = g_lvl[j-1].res_data;
      assign src_vld  = g_lvl[j-1].res_vld;
      assign src_sel  = g_lvl[j-1].res_sel;
    end

    estimador_mux_level #(
      .DATA_W(DATA_W),
      .N_IN  (N_IN_J),
      .SEL_W (SEL_W),
      .REG   (REG_AT[j+1])
    ) u_level (
      .ap_clk  (ap_clk),
      .ap_rst  (ap_rst),
      .ce      (ce),
      .src_vld (src_vld),
      .src_data(src_data),
      .src_sel (src_sel),
      .res_vld (res_vld),
      .res_data(res_data),
      .res_sel (res_sel)
    );
  end

  logic [SEL_W-1:0] sel_unused;
  assign sel_unused = g_lvl[SEL_W-1].res_sel;
  assign dout       = g_lvl[SEL_W-1].res_data;
  assign dout_vld   = g_lvl[SEL_W-1].res_vld;

endmodule

// File: tb/tb_estimador_pipe_mux.sv
// Directed bench for estimador_pipe_mux: default, 5-input/3-stage and 2-stage builds side by side.
module tb_estimador_pipe_mux;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp_dout;
    logic        exp_vld;
  } vec_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        din_vld;
  logic [95:0] din_a;
  logic [1:0]  sel_a;
  logic [79:0] din_b;
  logic [2:0]  sel_b;
  logic [31:0] dout_a;
  logic [31:0] dout_c;
  logic [15:0] dout_b;
  logic        dout_vld_a;
  logic        dout_vld_b;
  logic        dout_vld_c;
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
  logic        sel_err_a;
  logic        sel_err_b;
  logic        sel_err_c;
`endif

  int checks = 0;
  int passes = 0;

  always #5 ap_clk = ~ap_clk;

  estimador_pipe_mux #(.DATA_W(32), .NUM_IN(3), .NUM_STAGE(1)) dut_a (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .ce      (ce),
    .din_vld (din_vld),
    .din     (din_a),
    .sel     (sel_a),
    .dout    (dout_a),
    .dout_vld(dout_vld_a)
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
    ,
    .sel_err (sel_err_a)
`endif
  );

  estimador_pipe_mux #(.DATA_W(16), .NUM_IN(5), .NUM_STAGE(3)) dut_b (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .ce      (ce),
    .din_vld (din_vld),
    .din     (din_b),
    .sel     (sel_b),
    .dout    (dout_b),
    .dout_vld(dout_vld_b)
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
    ,
    .sel_err (sel_err_b)
`endif
  );

  estimador_pipe_mux #(.DATA_W(32), .NUM_IN(3), .NUM_STAGE(2)) dut_c (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .ce      (ce),
    .din_vld (din_vld),
    .din     (din_a),
    .sel     (sel_a),
    .dout    (dout_c),
    .dout_vld(dout_vld_c)
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
    ,
    .sel_err (sel_err_c)
`endif
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic [1:0] s, input logic [95:0] d);
    din_vld = vld;
    sel_a   = s;
    din_a   = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic doReset();
    @(negedge ap_clk);
    ap_rst  = 1'b1;
    din_vld = 1'b0;
    ce      = 1'b1;
    @(negedge ap_clk);
    ap_rst  = 1'b0;
  endtask

  function automatic logic [15:0] sweepWord(input int k);
    return 16'hA000 + 16'(k * 257);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] sel3_exp;
    logic [31:0] exp_c_dout;
    logic        exp_c_vld;
    logic [15:0] r0_word;
    logic [15:0] r2_word;
    logic [15:0] want_b;
    int          idx;

`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
    sel3_exp = 32'h0;
`else
    sel3_exp = 32'hCAFE_F00D;
`endif
    vecs[0]  = '{1'b1, 2'd0, 32'h1, 32'h2, 32'h3, 32'h1, 1'b1};
    vecs[1]  = '{1'b1, 2'd1, 32'h1, 32'h2, 32'h3, 32'h2, 1'b1};
    vecs[2]  = '{1'b1, 2'd2, 32'h1, 32'h2, 32'h3, 32'h3, 1'b1};
    vecs[3]  = '{1'b0, 2'd1, 32'd10, 32'd20, 32'd30, 32'h3, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 32'd10, 32'd20, 32'd30, 32'd20, 1'b1};
    vecs[5]  = '{1'b1, 2'd0, 32'hAAAA_5555, 32'h0, 32'hDEAD_BEEF, 32'hAAAA_5555, 1'b1};
    vecs[6]  = '{1'b1, 2'd3, 32'h1111, 32'h2222, 32'hCAFE_F00D, sel3_exp, 1'b1};
    vecs[7]  = '{1'b1, 2'd2, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[8]  = '{1'b0, 2'd0, 32'h99, 32'h98, 32'h97, 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 32'h99, 32'h98, 32'h97, 32'h1234_5678, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 32'h5, 32'h0F0F_0F0F, 32'h7, 32'h0F0F_0F0F, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 32'h8000_0000, 32'h1, 32'h2, 32'h8000_0000, 1'b1};

    ap_rst = 1'b1; ce = 1'b0; din_vld = 1'b0;
    sel_a = '0; din_a = '0; sel_b = '0; din_b = '0;
    #12;
    checkOutput("reset_a_dout", dout_a, 32'h0);
    checkOutput("reset_a_vld", 32'(dout_vld_a), 32'h0);
    checkOutput("reset_b_dout", 32'(dout_b), 32'h0);
    checkOutput("reset_b_vld", 32'(dout_vld_b), 32'h0);
    checkOutput("reset_c_dout", dout_c, 32'h0);
    checkOutput("reset_c_vld", 32'(dout_vld_c), 32'h0);
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
    checkOutput("reset_sel_err", 32'(sel_err_a), 32'h0);
`endif
    @(negedge ap_clk);
    ap_rst = 1'b0;
    ce     = 1'b1;

    // Table: latency-1 build checked directly, latency-2 build one record behind.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].sel, {vecs[i].c, vecs[i].b, vecs[i].a});
      tick();
      checkOutput($sformatf("vec%0d_a_dout", i), dout_a, vecs[i].exp_dout);
      checkOutput($sformatf("vec%0d_a_vld", i), 32'(dout_vld_a), 32'(vecs[i].exp_vld));
      if (i == 0) begin
        exp_c_dout = 32'h0;
        exp_c_vld  = 1'b0;
      end else begin
        exp_c_dout = vecs[i-1].exp_dout;
        exp_c_vld  = vecs[i-1].exp_vld;
      end
      checkOutput($sformatf("vec%0d_c_dout", i), dout_c, exp_c_dout);
      checkOutput($sformatf("vec%0d_c_vld", i), 32'(dout_vld_c), 32'(exp_c_vld));
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
      checkOutput($sformatf("vec%0d_sel_err", i), 32'(sel_err_a), (i >= 6) ? 32'h1 : 32'h0);
`endif
    end

    // Clock-enable stall with one sample inside the 2-stage pipe.
    doReset();
    applyStimulus(1'b1, 2'd1, {32'h3333, 32'h1111_2222, 32'h4444});
    tick();
    checkOutput("stall_pre_c_vld", 32'(dout_vld_c), 32'h0);
    checkOutput("stall_pre_a_dout", dout_a, 32'h1111_2222);
    ce = 1'b0;
    applyStimulus(1'b1, 2'd0, {32'h5555, 32'h6666, 32'h7777_7777});
    for (int n = 0; n < 4; n++) begin
      tick();
      checkOutput($sformatf("stall%0d_c_dout", n), dout_c, 32'h0);
      checkOutput($sformatf("stall%0d_c_vld", n), 32'(dout_vld_c), 32'h0);
      checkOutput($sformatf("stall%0d_a_dout", n), dout_a, 32'h1111_2222);
      checkOutput($sformatf("stall%0d_a_vld", n), 32'(dout_vld_a), 32'h1);
    end
    ce = 1'b1;
    applyStimulus(1'b0, 2'd0, {32'h5555, 32'h6666, 32'h7777_7777});
    tick();
    checkOutput("resume_c_dout", dout_c, 32'h1111_2222);
    checkOutput("resume_c_vld", 32'(dout_vld_c), 32'h1);
    checkOutput("resume_a_vld", 32'(dout_vld_a), 32'h0);
    tick();
    checkOutput("resume2_c_vld", 32'(dout_vld_c), 32'h0);
    checkOutput("resume2_c_dout", dout_c, 32'h1111_2222);

    // Five-input, three-stage build: din_vld 1,0,1 on sel=3 with random data.
    doReset();
    sel_b = 3'd3;
    for (int k = 0; k < 5; k++) din_b[k*16 +: 16] = 16'($urandom);
    r0_word = din_b[3*16 +: 16];
    din_vld = 1'b1;
    tick();
    checkOutput("b_lat1_vld", 32'(dout_vld_b), 32'h0);
    for (int k = 0; k < 5; k++) din_b[k*16 +: 16] = 16'($urandom);
    din_vld = 1'b0;
    tick();
    checkOutput("b_lat2_vld", 32'(dout_vld_b), 32'h0);
    for (int k = 0; k < 5; k++) din_b[k*16 +: 16] = 16'($urandom);
    r2_word = din_b[3*16 +: 16];
    din_vld = 1'b1;
    tick();
    checkOutput("b_s0_dout", 32'(dout_b), 32'(r0_word));
    checkOutput("b_s0_vld", 32'(dout_vld_b), 32'h1);
    for (int k = 0; k < 5; k++) din_b[k*16 +: 16] = 16'($urandom);
    din_vld = 1'b0;
    tick();
    checkOutput("b_bubble_dout", 32'(dout_b), 32'(r0_word));
    checkOutput("b_bubble_vld", 32'(dout_vld_b), 32'h0);
    tick();
    checkOutput("b_s2_dout", 32'(dout_b), 32'(r2_word));
    checkOutput("b_s2_vld", 32'(dout_vld_b), 32'h1);
    tick();
    checkOutput("b_tail_vld", 32'(dout_vld_b), 32'h0);

    // Back-to-back sweep of every sel code, including the ones past NUM_IN-1.
    for (int k = 0; k < 5; k++) din_b[k*16 +: 16] = sweepWord(k);
    for (int s = 0; s < 10; s++) begin
      din_vld = (s < 8);
      sel_b   = 3'(s);
      tick();
      if (s >= 2) begin
        idx = (s - 2 < 5) ? s - 2 : 4;
`ifdef ESTIMADOR_MUX_SEL_CHECK_EN
        want_b = (s - 2 >= 5) ? 16'h0 : sweepWord(idx);
`else
        want_b = sweepWord(idx);
`endif
        checkOutput($sformatf("sweep_sel%0d_dout", s - 2), 32'(dout_b), 32'(want_b));
        checkOutput($sformatf("sweep_sel%0d_vld", s - 2), 32'(dout_vld_b), 32'h1);
      end
    end

    // Asynchronous reset with two samples in flight in the 2-stage build.
    doReset();
    applyStimulus(1'b1, 2'd0, {32'h0, 32'h0, 32'h0000_00AB});
    tick();
    applyStimulus(1'b1, 2'd2, {32'h0000_00CD, 32'h0, 32'h0});
    tick();
    checkOutput("flight_pre_c_dout", dout_c, 32'h0000_00AB);
    din_vld = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    checkOutput("async_c_dout", dout_c, 32'h0);
    checkOutput("async_c_vld", 32'(dout_vld_c), 32'h0);
    checkOutput("async_a_dout", dout_a, 32'h0);
    checkOutput("async_a_vld", 32'(dout_vld_a), 32'h0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput($sformatf("post_rst%0d_c_vld", n), 32'(dout_vld_c), 32'h0);
      checkOutput($sformatf("post_rst%0d_c_dout", n), dout_c, 32'h0);
      checkOutput($sformatf("post_rst%0d_b_vld", n), 32'(dout_vld_b), 32'h0);
    end
    applyStimulus(1'b1, 2'd1, {32'h0, 32'h0000_BEEF, 32'h0});
    tick();
    checkOutput("first_acc_a_dout", dout_a, 32'h0000_BEEF);
    din_vld = 1'b0;
    tick();
    checkOutput("first_acc_c_dout", dout_c, 32'h0000_BEEF);
    checkOutput("first_acc_c_vld", 32'(dout_vld_c), 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
